// File: rtl/foo_pkg.sv
// rtl/foo_pkg.sv - shared FSM state type, default latency and datapath constants
package foo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int FOO_LATENCY = 11;
    localparam int FOO_ADD_A   = 4;
    localparam int FOO_ADD_B   = 7;
    localparam int FOO_DIV     = 3;
    localparam int FOO_ADD_C   = 120;

endpackage

// File: rtl/foo_rr_arbiter.sv
// rtl/foo_rr_arbiter.sv - round-robin one-hot grant with priority pointer
module foo_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        if (en && !rst) begin
            for (int off = 0; off < NREQ; off++) begin
                idx = IW'((int'(ptr_q) + off) % NREQ);
                if (!grant_valid && req_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx;
                    grant[idx]  = 1'b1;
                end
            end
        end
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = IW'((int'(grant_idx) + 1) % NREQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/foo_true_pipelined.sv
// rtl/foo_true_pipelined.sv - c = ((a+4)*(b+7)/3+120)^2 mod 2^DATA_WIDTH, LATENCY cycles
module foo_true_pipelined
    import foo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = FOO_LATENCY
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] c
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * W + 2;
    localparam int ND = LATENCY - 3;

    logic [W:0]    sa_q, sa_d, sb_q, sb_d;
    logic [PW-1:0] prod_q, prod_d;
    logic [W-1:0]  base_q, base_d;
    logic [W-1:0]  sq_q [ND];
    logic [W-1:0]  sq_d [ND];

    // Product and quotient are kept full width so the divide sees the exact value.
    always_comb begin
        sa_d     = {1'b0, a} + (W+1)'(FOO_ADD_A);
        sb_d     = {1'b0, b} + (W+1)'(FOO_ADD_B);
        prod_d   = PW'(sa_q) * PW'(sb_q);
        base_d   = W'(prod_q / PW'(FOO_DIV) + PW'(FOO_ADD_C));
        sq_d[0]  = base_q * base_q;
        for (int i = 1; i < ND; i++) begin
            sq_d[i] = sq_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        sa_q   <= sa_d;
        sb_q   <= sb_d;
        prod_q <= prod_d;
        base_q <= base_d;
        sq_q   <= sq_d;
    end

    assign c = sq_q[ND-1];

endmodule

// File: rtl/foo_pipe_arbiter.sv
// rtl/foo_pipe_arbiter.sv - NREQ requesters share one pipelined datapath; FOO_PIPE_ARB_STATS_EN adds grant counters
module foo_pipe_arbiter
    import foo_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = FOO_LATENCY
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0]     req_a,
    input  logic [NREQ*DATA_WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]                req_ready,
    output logic [NREQ-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_c,
    output logic                           busy,
`ifdef FOO_PIPE_ARB_STATS_EN
    output logic [NREQ*16-1:0]             stat_grants,
`endif
    output logic [$clog2(LATENCY+1)-1:0]   inflight
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LATENCY + 1);

    logic [NREQ-1:0]       grant;
    logic                  issue;
    logic [IW-1:0]         grant_idx;
    logic [DATA_WIDTH-1:0] op_a, op_b, dp_c;

    state_t                state_q, state_d;
    logic [LATENCY-1:0]    tag_valid_q, tag_valid_d;
    logic [IW-1:0]         tag_id_q [LATENCY];
    logic [IW-1:0]         tag_id_d [LATENCY];
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] rsp_hold_q, rsp_hold_d;
    logic                  retire;

    foo_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_valid  (req_valid),
        .grant      (grant),
        .grant_valid(issue),
        .grant_idx  (grant_idx)
    );

    assign req_ready = grant;
    assign op_a = req_a[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign op_b = req_b[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    foo_true_pipelined #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY)) u_dp (
        .clk(clk),
        .a  (op_a),
        .b  (op_b),
        .c  (dp_c)
    );

    assign retire    = tag_valid_q[LATENCY-1];
    assign rsp_valid = retire ? (NREQ'(1) << tag_id_q[LATENCY-1]) : '0;
    assign rsp_c     = retire ? dp_c : rsp_hold_q;
    assign busy      = (state_q != ST_IDLE);
    assign inflight  = inflight_q;

    always_comb begin
        tag_valid_d = {tag_valid_q[LATENCY-2:0], issue};
        tag_id_d[0] = grant_idx;
        for (int i = 1; i < LATENCY; i++) begin
            tag_id_d[i] = tag_id_q[i-1];
        end
        rsp_hold_d = rsp_c;

        inflight_d = inflight_q;
        case ({issue, retire})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!issue && inflight_d == '0) state_d = ST_IDLE;
                else if (!en)                   state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (en && issue)              state_d = ST_RUN;
                else if (inflight_d == '0)    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clearing the tag valids is what drops in-flight results at reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tag_valid_q <= '0;
            inflight_q  <= '0;
            rsp_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            tag_valid_q <= tag_valid_d;
            inflight_q  <= inflight_d;
            rsp_hold_q  <= rsp_hold_d;
        end
        tag_id_q <= tag_id_d;
    end

`ifdef FOO_PIPE_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];
    logic [15:0] cnt_d [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
            stat_grants[i*16 +: 16] = cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_foo_pipe_arbiter.sv
// tb/tb_foo_pipe_arbiter.sv - directed self-checking bench for foo_pipe_arbiter
module tb_foo_pipe_arbiter;
    import foo_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [3:0]   req_valid;
    logic [127:0] req_a, req_b;
    logic [3:0]   req_ready, rsp_valid;
    logic [31:0]  rsp_c;
    logic         busy;
    logic [3:0]   inflight;
`ifdef FOO_PIPE_ARB_STATS_EN
    logic [63:0]  stat_grants;
`endif

    int n_checks = 0;
    int n_errors = 0;

    foo_pipe_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_c      (rsp_c),
        .busy       (busy),
`ifdef FOO_PIPE_ARB_STATS_EN
        .stat_grants(stat_grants),
`endif
        .inflight   (inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic reset_dut();
        step();
        rst = 1'b1;
        en = 1'b1;
        req_valid = 4'b1111;
        #1 chk("rst_ready", 64'(req_ready), 64'd0);
        step();
        step();
        rst = 1'b0;
        req_valid = 4'b0000;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_c", 64'(rsp_c), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
    endtask

    task automatic issue_all4(input string tag);
        logic [3:0] exp_g;
        req_valid = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            exp_g = 4'b0001 << g;
            #1 chk(tag, 64'(req_ready), 64'(exp_g));
            step();
            req_valid[g] = 1'b0;
        end
    endtask

    logic [31:0] exp_c [4];
    logic [3:0]  exp_v;
    int          nres;
    int          ngr;

    initial begin
        rst = 1'b1;
        en = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        exp_c[0] = 32'd16641;
        exp_c[1] = 32'd22500;
        exp_c[2] = 32'd30976;
        exp_c[3] = 32'd18225;

        // single op from requester 0
        reset_dut();
        set_op(0, 32'd1, 32'd2);
        req_valid = 4'b0001;
        #1 chk("t1_ready", 64'(req_ready), 64'd1);
        for (int k = 1; k <= 11; k++) begin
            step();
            req_valid = 4'b0000;
            #1;
            if (k < 11) begin
                if (rsp_valid != 4'b0000) chk("t1_early_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
                chk("t1_rsp_c", 64'(rsp_c), 64'd18225);
            end
        end
        step();
        #1;
        chk("t1_inflight", 64'(inflight), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_hold_valid", 64'(rsp_valid), 64'd0);
        chk("t1_hold_c", 64'(rsp_c), 64'd18225);

        // four requesters back to back
        reset_dut();
        set_op(0, 32'd0, 32'd0);
        set_op(1, 32'd5, 32'd3);
        set_op(2, 32'd10, 32'd5);
        set_op(3, 32'd1, 32'd2);
        issue_all4("t2_grant");
        for (int c = 4; c <= 15; c++) begin
            #1;
            if (c >= 11 && c <= 14) begin
                exp_v = 4'b0001 << (c - 11);
                chk("t2_rsp_valid", 64'(rsp_valid), 64'(exp_v));
                chk("t2_rsp_c", 64'(rsp_c), 64'(exp_c[c-11]));
            end else if (c == 15) begin
                chk("t2_rsp_end", 64'(rsp_valid), 64'd0);
            end
            step();
        end

        // en dropped after three issues
        reset_dut();
        req_valid = 4'b0111;
        for (int g = 0; g < 3; g++) begin
            exp_v = 4'b0001 << g;
            #1 chk("t3_grant", 64'(req_ready), 64'(exp_v));
            step();
            req_valid[g] = 1'b0;
        end
        en = 1'b0;
        req_valid = 4'b1000;
        #1 chk("t3_ready_off", 64'(req_ready), 64'd0);
        step();
        #1;
        chk("t3_drain", 64'(dut.state_q), 64'(ST_DRAIN));
        chk("t3_busy_drain", 64'(busy), 64'd1);
        nres = 0;
        for (int c = 4; c <= 14; c++) begin
            #1;
            if (rsp_valid != 4'b0000) begin
                exp_v = (nres < 4) ? (4'b0001 << nres) : 4'b0000;
                chk("t3_rsp_valid", 64'(rsp_valid), 64'(exp_v));
                chk("t3_rsp_c", 64'(rsp_c), 64'(exp_c[nres % 4]));
                nres++;
            end
            step();
        end
        #1;
        chk("t3_nres", 64'(nres), 64'd3);
        chk("t3_idle", 64'(dut.state_q), 64'(ST_IDLE));
        chk("t3_busy_end", 64'(busy), 64'd0);
        chk("t3_inflight", 64'(inflight), 64'd0);
        chk("t3_ready_still_off", 64'(req_ready), 64'd0);
        en = 1'b1;
        req_valid = 4'b0000;

        // reset with operations in flight
        reset_dut();
        issue_all4("t4_grant");
        for (int c = 4; c < 8; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 chk("t4_inflight_rst", 64'(inflight), 64'd0);
        nres = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid != 4'b0000) nres++;
            step();
        end
        chk("t4_no_rsp", 64'(nres), 64'd0);
        chk("t4_inflight_end", 64'(inflight), 64'd0);

        // single requester streaming for twelve cycles
        reset_dut();
        set_op(2, 32'd1, 32'd2);
        req_valid = 4'b0100;
        ngr = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready == 4'b0100) ngr++;
            if (c == 11) begin
                chk("t5_inflight_sat", 64'(inflight), 64'd11);
                chk("t5_rsp_valid", 64'(rsp_valid), 64'd4);
                chk("t5_rsp_c", 64'(rsp_c), 64'd18225);
            end
            step();
        end
        req_valid = 4'b0000;
        #1;
        chk("t5_grants", 64'(ngr), 64'd12);
        chk("t5_inflight_same", 64'(inflight), 64'd11);
        step();
        #1 chk("t5_inflight_dec", 64'(inflight), 64'd10);

`ifdef FOO_PIPE_ARB_STATS_EN
        reset_dut();
        for (int r = 0; r < 5; r++) issue_all4("t6_grant");
        req_valid = 4'b0000;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t6_stat", 64'(stat_grants[i*16 +: 16]), 64'd5);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
